// File: rtl/rca_seq_adder.sv
// rca_seq_adder: multi-cycle ripple-carry adder/subtractor.
//
// Adds CHUNK bits per clock, least significant chunk first. The carry
// between chunks is held in a register. Operands arrive on a valid/ready
// handshake and results leave on another one.
//
// Parameters
//   WIDTH  operand/result width; must be a multiple of CHUNK
//   CHUNK  bits added per cycle (1..WIDTH)
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand request
//   in_ready   high while idle; operands are accepted on in_valid & in_ready
//   a, b       operands
//   cin        carry-in for add; ignored for subtract
//   sub        0: a + b + cin, 1: a - b (a + ~b + 1)
//   out_valid  result available; held until out_ready
//   out_ready  consumer accepts the result
//   sum        result modulo 2^WIDTH
//   cout       carry out of the MSB (for subtract, 1 = no borrow)
//   ovf        two's-complement overflow
//
// States
//   IDLE | waiting for operands, in_ready = 1
//   RUN  | adding one chunk per cycle, counter k selects the chunk
//   DONE | result presented, waiting for out_ready
module rca_seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic             carry;
  // Operands are shifted right one chunk per cycle, so the active chunk is
  // always the low CHUNK bits. This avoids a variable part-select on k.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // The partial sum fills from the top. After NCHUNK shifts, chunk 0 sits
  // in the low bits.
  logic [WIDTH-1:0] psum;

  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK-1:0] s_ch;
  logic             c_ch;
  logic             c_msb;
  logic             last;
  logic [WIDTH-1:0] s_ext;
  logic [WIDTH-1:0] psum_next;

  assign in_ready = (state == IDLE);

  always_comb begin
    a_ch = a_sh[CHUNK-1:0];
    b_ch = b_sh[CHUNK-1:0];
    {c_ch, s_ch} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry};
    // Carry into the chunk's top bit, recovered from its sum bit. On the
    // last chunk this is the carry into bit WIDTH-1. When CHUNK = 1 it
    // reduces to the carry register.
    c_msb = s_ch[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];
    s_ext = '0;
    s_ext[CHUNK-1:0] = s_ch;
    psum_next = (psum >> CHUNK) | (s_ext << (WIDTH - CHUNK));
    last = (k == K_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      carry     <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      psum      <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b ^ {WIDTH{sub}};
            carry <= sub | cin;
            k     <= '0;
            psum  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> CHUNK;
          b_sh  <= b_sh >> CHUNK;
          psum  <= psum_next;
          carry <= c_ch;
          if (last) begin
            sum       <= psum_next;
            cout      <= c_ch;
            ovf       <= c_msb ^ c_ch;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_seq_adder.sv
module tb_rca_seq_adder;

  localparam int N_SW = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst_n_sw;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        cin, sub, cout, ovf;

  int errors = 0;
  int checks = 0;
  bit sw_done [4];

  always #5 clk = ~clk;

  rca_seq_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the mathematical values.
  // Returns {ovf, cout, sum[63:0]}.
  function automatic logic [65:0] ref_add(input longint unsigned x, input longint unsigned y,
                                          input int w, input logic c, input logic s);
    longint unsigned modv, hu, full, res;
    longint sx, sy, r, half;
    logic co, ov;
    modv = 64'd1 << w;
    hu   = modv >> 1;
    half = longint'(hu);
    sx = (x >= hu) ? longint'(x) - longint'(modv) : longint'(x);
    sy = (y >= hu) ? longint'(y) - longint'(modv) : longint'(y);
    if (s) begin
      res = (x - y) % modv;
      co  = (x >= y);
      r   = sx - sy;
    end else begin
      full = x + y + 64'(c);
      res  = full % modv;
      co   = (full >= modv);
      r    = sx + sy + longint'(c);
    end
    ov = (r >= half) || (r < -half);
    return {ov, co, res};
  endfunction

  // Runs one operation on u_dut, starting from IDLE at #1 after an edge.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        input logic ts, output logic [15:0] rs, output logic rc,
                        output logic ro, output int lat);
    int n;
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
    cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
    rs = sum; rc = cout; ro = ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Randomized sweeps, one instance per configuration, run concurrently.
  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int W  = (g == 3) ? 32 : 16;
    localparam int C  = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 16 : 8;
    localparam int NC = W / C;
    localparam logic [W-1:0] MSBV = {1'b1, {(W-1){1'b0}}};

    logic         iv, ir, ov, orr, ic, isb, co, ovf_s;
    logic [W-1:0] ia, ib, ss;

    rca_seq_adder #(.WIDTH(W), .CHUNK(C)) u_sw (
      .clk(clk), .rst_n(rst_n_sw), .in_valid(iv), .in_ready(ir),
      .a(ia), .b(ib), .cin(ic), .sub(isb), .out_valid(ov),
      .out_ready(orr), .sum(ss), .cout(co), .ovf(ovf_s)
    );

    initial begin
      logic [65:0]  r;
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      int           lat, d, sel;
      iv = 1'b0; orr = 1'b0; ia = '0; ib = '0; ic = 1'b0; isb = 1'b0;
      @(posedge rst_n_sw);
      @(posedge clk); #1;
      for (int i = 0; i < N_SW; i++) begin
        sel = $urandom_range(0, 9);
        ra = (sel == 0) ? '0 : (sel == 1) ? '1 : (sel == 2) ? MSBV : W'({$urandom, $urandom});
        sel = $urandom_range(0, 9);
        rb = (sel == 0) ? '0 : (sel == 1) ? '1 : (sel == 2) ? ~MSBV : W'({$urandom, $urandom});
        rc = 1'($urandom);
        rs = 1'($urandom);
        d = $urandom_range(0, 2);
        repeat (d) begin @(posedge clk); #1; end
        ia = ra; ib = rb; ic = rc; isb = rs; iv = 1'b1;
        @(posedge clk); #1;
        ia = W'({$urandom, $urandom}); ib = W'({$urandom, $urandom});
        ic = 1'($urandom); isb = 1'($urandom);
        lat = 0;
        while (!ov && lat < 4 * NC + 8) begin
          iv = 1'($urandom);
          orr = 1'($urandom);
          @(posedge clk); #1;
          lat++;
        end
        orr = 1'b0;
        r = ref_add(64'(ra), 64'(rb), W, rc, rs);
        chk($sformatf("cfg%0d_latency", g), 64'(lat), 64'(NC));
        chk($sformatf("cfg%0d_sum", g), 64'(ss), r[63:0]);
        chk($sformatf("cfg%0d_cout", g), 64'(co), 64'(r[64]));
        chk($sformatf("cfg%0d_ovf", g), 64'(ovf_s), 64'(r[65]));
        d = $urandom_range(0, 3);
        repeat (d) begin
          @(posedge clk); #1;
          chk($sformatf("cfg%0d_hold", g), 64'({ov, ss}), 64'({1'b1, r[W-1:0]}));
        end
        orr = 1'b1;
        @(posedge clk); #1;
        orr = 1'b0; iv = 1'b0;
        chk($sformatf("cfg%0d_release", g), 64'({ov, ir}), 64'b01);
      end
      sw_done[g] = 1'b1;
    end
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  initial begin
    vec_t        vecs [11];
    logic [15:0] rs;
    logic        rc, ro, rdy, all_done;
    int          lat, n, cyc, w;
    int          acc_q [$];

    vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[8]  = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[9]  = '{16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[10] = '{16'h0001, 16'h0002, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};

    rst_n = 1'b0; rst_n_sw = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #7;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_sum", 64'(sum), 64'd0);
    chk("reset_cout_ovf", 64'({cout, ovf}), 64'd0);
    #6;
    rst_n = 1'b1; rst_n_sw = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rs, rc, ro, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
      chk($sformatf("vec%0d_sum", i), 64'(rs), 64'(vecs[i].sum));
      chk($sformatf("vec%0d_cout", i), 64'(rc), 64'(vecs[i].cout));
      chk($sformatf("vec%0d_ovf", i), 64'(ro), 64'(vecs[i].ovf));
    end

    // Back-to-back operations with out_ready held high.
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      rdy = in_ready;
      @(posedge clk);
      cyc++;
      if (rdy) acc_q.push_back(cyc);
      #1;
    end
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("tput_accept_count", 64'(acc_q.size() >= 3), 64'd1);
    if (acc_q.size() >= 3) begin
      chk("tput_period_1", 64'(acc_q[1] - acc_q[0]), 64'd6);
      chk("tput_period_2", 64'(acc_q[2] - acc_q[1]), 64'd6);
    end

    // Backpressure: result held while out_ready stays low.
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 64) begin @(posedge clk); #1; n++; end
    chk("bp_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
      chk("bp_hold_result", 64'({sum, cout, ovf}), 64'({16'h5555, 2'b00}));
      chk("bp_hold_flags", 64'({out_valid, in_ready}), 64'b10);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release", 64'({out_valid, in_ready}), 64'b01);
    run_op(16'h00F0, 16'h0F10, 1'b0, 1'b0, rs, rc, ro, lat);
    chk("bp_next_sum", 64'(rs), 64'h1000);
    chk("bp_next_latency", 64'(lat), 64'd4);

    // Reset two cycles into RUN.
    a = 16'h7FFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_run_out_valid", 64'(out_valid), 64'd0);
    chk("rst_run_sum", 64'(sum), 64'd0);
    chk("rst_run_in_ready", 64'(in_ready), 64'd1);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("rst_run_no_stale", 64'({out_valid, in_ready}), 64'b01);
    end
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
    chk("rst_run_fresh_sum", 64'(rs), 64'h0002);
    chk("rst_run_fresh_latency", 64'(lat), 64'd4);

    // Reset while a result waits in DONE.
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 64) begin @(posedge clk); #1; n++; end
    chk("rst_done_pre_cout", 64'({out_valid, cout}), 64'b11);
    rst_n = 1'b0;
    #1;
    chk("rst_done_outputs", 64'({out_valid, cout, ovf, sum}), 64'd0);
    chk("rst_done_in_ready", 64'(in_ready), 64'd1);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_done_no_stale", 64'(out_valid), 64'd0);
    end
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
    chk("rst_done_fresh_sum", 64'(rs), 64'h0002);

    w = 0;
    all_done = 1'b0;
    while (!all_done && w < 80000) begin
      @(posedge clk);
      w++;
      all_done = sw_done[0] && sw_done[1] && sw_done[2] && sw_done[3];
    end
    chk("sweep_complete", 64'(all_done), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
